// File: rtl/operand_forward_unit.sv
// ---------------------------------------------------------------------------
// operand_forward_unit
//
// Purpose:
//   Consumer end of the forwarding bus. Resolves the rs1/rs2 operand values
//   for the instruction in decode from three bypass records (EX, MEM, WB) or
//   from the register file. It stalls decode when an operand depends on a
//   result that is not final yet. Resolved operands are then registered into
//   the ID/EX boundary under a valid/ready handshake.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 kill the ID/EX instruction and block capture
//   id_valid / id_ready   decode-side handshake
//   id_rs1, id_rs2        source register indices
//   rf_rs1_data/rs2_data  combinational register-file read data
//   fwd_ex/mem/wb         bypass records (data_valid, data, address)
//   ex_valid / ex_ready   execute-side handshake
//   ex_rs1/2_data         resolved operands
//   ex_rs1/2_src          operand source: 0=RF, 1=WB, 2=MEM, 3=EX
//   stall_cycles          saturating count of hazard-stall cycles
//   hazard_timeout        sticky flag: hazard lasted STALL_LIMIT cycles
// ---------------------------------------------------------------------------
package forwarding;
  typedef struct packed {
    logic        data_valid;
    logic [31:0] data;
    logic [4:0]  address;
  } t;
endpackage

module operand_forward_unit #(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [31:0]      rf_rs1_data,
  input  logic [31:0]      rf_rs2_data,
  input  forwarding::t     fwd_ex,
  input  forwarding::t     fwd_mem,
  input  forwarding::t     fwd_wb,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [31:0]      ex_rs1_data,
  output logic [31:0]      ex_rs2_data,
  output logic [1:0]       ex_rs1_src,
  output logic [1:0]       ex_rs2_src,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             hazard_timeout
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_WB  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_EX  = 2'd3;

  typedef struct packed {
    logic        hazard;
    logic [1:0]  src;
    logic [31:0] data;
  } resolved_t;

  // First address match in EX > MEM > WB order wins. An unresolved winner is
  // a hazard: an older (lower-priority) value would be stale, so it is never
  // used as a fallback. Index 0 is hardwired zero and never hazards.
  function automatic resolved_t resolve_operand(
    input logic [4:0]   idx,
    input logic [31:0]  rf,
    input forwarding::t ex,
    input forwarding::t mem,
    input forwarding::t wb
  );
    resolved_t r;
    r.hazard = 1'b0;
    r.src    = SRC_RF;
    r.data   = rf;
    if (idx == 5'd0) begin
      r.data = '0;
    end else if (ex.address == idx) begin
      if (ex.data_valid) begin
        r.data = ex.data;
        r.src  = SRC_EX;
      end else begin
        r.hazard = 1'b1;
      end
    end else if (mem.address == idx) begin
      if (mem.data_valid) begin
        r.data = mem.data;
        r.src  = SRC_MEM;
      end else begin
        r.hazard = 1'b1;
      end
    end else if (wb.address == idx) begin
      if (wb.data_valid) begin
        r.data = wb.data;
        r.src  = SRC_WB;
      end else begin
        r.hazard = 1'b1;
      end
    end
    return r;
  endfunction

  logic [1:0][4:0]  rs_idx;
  logic [1:0][31:0] rf_data;
  resolved_t [1:0]  res;
  logic [1:0]       res_hazard;

  assign rs_idx  = {id_rs2, id_rs1};
  assign rf_data = {rf_rs2_data, rf_rs1_data};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign res[gi]        = resolve_operand(rs_idx[gi], rf_data[gi], fwd_ex, fwd_mem, fwd_wb);
      assign res_hazard[gi] = res[gi].hazard;
    end
  endgenerate

  logic                 ex_valid_reg;
  logic [1:0][31:0]     ex_data_reg;
  logic [1:0][1:0]      ex_src_reg;
  logic [CNT_W-1:0]     stall_cnt_reg;
  logic [RUN_W-1:0]     run_cnt_reg;
  logic                 timeout_reg;

  logic hazard;
  logic slot_free;
  logic accept;
  logic stall_event;
  logic run_hit;

  assign hazard    = id_valid & (|res_hazard);
  assign slot_free = ~ex_valid_reg | ex_ready;
  // Reset is folded in so decode never sees a handshake while state clears.
  assign id_ready  = ~reset & ~hazard & slot_free & ~flush;
  assign accept    = id_valid & id_ready;

  // A flushed cycle does not count as a stall: the stalled instruction is
  // being discarded, and flush also restarts the consecutive-hazard run.
  assign stall_event = hazard & ~flush;
  assign run_hit     = (run_cnt_reg >= RUN_W'(STALL_LIMIT - 1));

  // ID/EX boundary register
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
      ex_data_reg  <= '0;
      ex_src_reg   <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (accept) begin
      ex_valid_reg <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        ex_data_reg[i] <= res[i].data;
        ex_src_reg[i]  <= res[i].src;
      end
    end else if (ex_ready) begin
      ex_valid_reg <= 1'b0;
    end
  end

  // Stall statistics and timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      run_cnt_reg   <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      if (stall_event && stall_cnt_reg != {CNT_W{1'b1}}) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (stall_event) begin
        // Saturate at the limit; the sticky flag carries the information.
        if (!run_hit || run_cnt_reg < RUN_W'(STALL_LIMIT)) begin
          run_cnt_reg <= run_cnt_reg + 1'b1;
        end
        if (run_hit) begin
          timeout_reg <= 1'b1;
        end
      end else begin
        run_cnt_reg <= '0;
      end
    end
  end

  assign ex_valid       = ex_valid_reg;
  assign ex_rs1_data    = ex_data_reg[0];
  assign ex_rs2_data    = ex_data_reg[1];
  assign ex_rs1_src     = ex_src_reg[0];
  assign ex_rs2_src     = ex_src_reg[1];
  assign stall_cycles   = stall_cnt_reg;
  assign hazard_timeout = timeout_reg;

endmodule

// File: tb/tb_operand_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_operand_forward_unit
//
// Purpose:
//   Self-checking bench for operand_forward_unit. A driver applies directed
//   and random stimulus once per cycle and keeps a behavioural reference
//   model. Every accepted instruction's expected operands are pushed into a
//   scoreboard queue. A separate monitor pops that queue whenever execute
//   consumes the ID/EX register, and compares the two results.
// ---------------------------------------------------------------------------
module tb_operand_forward_unit;

  localparam int STALL_LIMIT = 15;
  localparam int CNT_W       = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [4:0]         id_rs1;
  logic [4:0]         id_rs2;
  logic [31:0]        rf_rs1_data;
  logic [31:0]        rf_rs2_data;
  forwarding::t       fwd_ex;
  forwarding::t       fwd_mem;
  forwarding::t       fwd_wb;
  logic               ex_valid;
  logic               ex_ready;
  logic [31:0]        ex_rs1_data;
  logic [31:0]        ex_rs2_data;
  logic [1:0]         ex_rs1_src;
  logic [1:0]         ex_rs2_src;
  logic [CNT_W-1:0]   stall_cycles;
  logic               hazard_timeout;

  operand_forward_unit #(
    .STALL_LIMIT(STALL_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .rf_rs1_data   (rf_rs1_data),
    .rf_rs2_data   (rf_rs2_data),
    .fwd_ex        (fwd_ex),
    .fwd_mem       (fwd_mem),
    .fwd_wb        (fwd_wb),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rs1_src    (ex_rs1_src),
    .ex_rs2_src    (ex_rs2_src),
    .stall_cycles  (stall_cycles),
    .hazard_timeout(hazard_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  s1;
    logic [1:0]  s2;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_ex_valid = 1'b0;
  logic [31:0] m_stall    = '0;
  int          m_run      = 0;
  bit          m_timeout  = 1'b0;

  function automatic forwarding::t mk(input bit v, input logic [31:0] d, input logic [4:0] a);
    forwarding::t r;
    r.data_valid = v;
    r.data       = d;
    r.address    = a;
    return r;
  endfunction

  // Reference operand resolution. Records are scanned from youngest to
  // oldest; the youngest writer of a register determines its value.
  function automatic void model_resolve(
    input  logic [4:0]   idx,
    input  logic [31:0]  rf,
    input  forwarding::t ex,
    input  forwarding::t mem,
    input  forwarding::t wb,
    output logic [31:0]  d,
    output logic [1:0]   s,
    output bit           hz
  );
    forwarding::t recs[3];
    recs[0] = ex;
    recs[1] = mem;
    recs[2] = wb;
    d  = rf;
    s  = 2'd0;
    hz = 1'b0;
    if (idx == 5'd0) begin
      d = 32'd0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (recs[i].address != 5'd0 && recs[i].address == idx) begin
        if (recs[i].data_valid) begin
          d = recs[i].data;
          s = 2'(3 - i);
        end else begin
          hz = 1'b1;
        end
        return;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One cycle: drive inputs, check combinational id_ready, clock, then check
  // the registered outputs. Entered and left at posedge + 1.
  task automatic step(
    input bit           rst,
    input bit           fl,
    input bit           iv,
    input bit           er,
    input logic [4:0]   r1,
    input logic [4:0]   r2,
    input logic [31:0]  rd1,
    input logic [31:0]  rd2,
    input forwarding::t e,
    input forwarding::t m,
    input forwarding::t w
  );
    logic [31:0] d1, d2;
    logic [1:0]  s1, s2;
    bit          h1, h2, hz, exp_ready, accept;
    exp_t        item;

    reset = rst; flush = fl; id_valid = iv; ex_ready = er;
    id_rs1 = r1; id_rs2 = r2; rf_rs1_data = rd1; rf_rs2_data = rd2;
    fwd_ex = e; fwd_mem = m; fwd_wb = w;
    #1;

    model_resolve(r1, rd1, e, m, w, d1, s1, h1);
    model_resolve(r2, rd2, e, m, w, d2, s2, h2);
    hz        = iv && (h1 || h2);
    exp_ready = !rst && !hz && (!m_ex_valid || er) && !fl;
    accept    = iv && exp_ready;
    chk("id_ready", {31'd0, id_ready}, {31'd0, exp_ready});

    if (rst) begin
      scoreboard.delete();
      m_ex_valid = 1'b0;
      m_stall    = '0;
      m_run      = 0;
      m_timeout  = 1'b0;
    end else begin
      // A flushed instruction never reaches execute.
      if (fl && m_ex_valid && scoreboard.size() > 0) void'(scoreboard.pop_front());
      if (accept) begin
        item.d1 = d1; item.d2 = d2; item.s1 = s1; item.s2 = s2;
        scoreboard.push_back(item);
      end
      if (fl)          m_ex_valid = 1'b0;
      else if (accept) m_ex_valid = 1'b1;
      else if (er)     m_ex_valid = 1'b0;
      if (hz && !fl) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        m_run = m_run + 1;
        if (m_run >= STALL_LIMIT) m_timeout = 1'b1;
      end else begin
        m_run = 0;
      end
    end

    @(posedge clk);
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_valid});
    chk("stall_cycles", stall_cycles, m_stall);
    chk("hazard_timeout", {31'd0, hazard_timeout}, {31'd0, m_timeout});
    if (rst) begin
      chk("reset_rs1_data", ex_rs1_data, 32'd0);
      chk("reset_rs2_data", ex_rs2_data, 32'd0);
      chk("reset_src", {28'd0, ex_rs2_src, ex_rs1_src}, 32'd0);
    end
  endtask

  // Monitor: execute consumes the ID/EX register on this edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && flush === 1'b0 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
        if (scoreboard.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: rs1=%h rs2=%h, expected no instruction", ex_rs1_data, ex_rs2_data);
        end else begin
          e = scoreboard.pop_front();
          chk("ex_rs1_data", ex_rs1_data, e.d1);
          chk("ex_rs2_data", ex_rs2_data, e.d2);
          chk("ex_rs1_src", {30'd0, ex_rs1_src}, {30'd0, e.s1});
          chk("ex_rs2_src", {30'd0, ex_rs2_src}, {30'd0, e.s2});
          $display("xfer rs1=%h/%0d rs2=%h/%0d", ex_rs1_data, ex_rs1_src, ex_rs2_data, ex_rs2_src);
        end
      end
    end
  end

  function automatic forwarding::t rand_rec();
    return mk($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)));
  endfunction

  initial begin
    forwarding::t none;
    none = mk(1'b0, 32'd0, 5'd0);
    reset = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    id_rs1 = '0; id_rs2 = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    fwd_ex = none; fwd_mem = none; fwd_wb = none;
    @(posedge clk);
    #1;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, none, none, none);
    step(1, 0, 0, 0, 0, 0, 0, 0, none, none, none);

    // Load-use stall followed by resolution from MEM
    step(0, 0, 1, 1, 7, 0, 32'h1111, 0, mk(0, 32'h5555, 7), none, none);
    step(0, 0, 1, 1, 7, 0, 32'h1111, 0, none, mk(1, 32'hDEAD_BEEF, 7), none);
    step(0, 0, 0, 1, 0, 0, 0, 0, none, none, none);

    // Priority EX > MEM > WB, then with EX ignored
    step(0, 0, 1, 1, 3, 3, 32'h9, 32'h9, mk(1, 32'h1, 3), mk(1, 32'h2, 3), mk(1, 32'h3, 3));
    step(0, 0, 1, 1, 3, 3, 32'h9, 32'h9, mk(1, 32'h1, 0), mk(1, 32'h2, 3), mk(1, 32'h3, 3));
    // x0 immunity
    step(0, 0, 1, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(0, 32'h0, 0), none, none);
    step(0, 0, 0, 1, 0, 0, 0, 0, none, none, none);

    // Backpressure, then flush
    step(0, 0, 1, 0, 5, 6, 32'hA5, 32'h5A, none, none, none);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4, 4, 32'h44, 32'h44, none, none, none);
    step(0, 1, 1, 0, 4, 4, 32'h44, 32'h44, none, none, none);
    step(0, 0, 0, 1, 0, 0, 0, 0, none, none, none);

    // Timeout: 15 hazard cycles, release, 14 more
    for (int i = 0; i < 15; i++) step(0, 0, 1, 1, 7, 0, 0, 0, mk(0, 32'h0, 7), none, none);
    step(0, 0, 0, 1, 0, 0, 0, 0, none, none, none);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 1, 0, 7, 0, 0, none, mk(0, 32'h0, 7), none);

    // Reset mid-stall with a valid ID/EX entry
    step(0, 0, 1, 0, 2, 2, 32'h22, 32'h22, none, none, none);
    step(0, 0, 1, 0, 7, 0, 0, 0, mk(0, 32'h0, 7), none, none);
    step(1, 0, 1, 0, 7, 0, 0, 0, mk(0, 32'h0, 7), none, none);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7,
           5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
           $urandom, $urandom, rand_rec(), rand_rec(), rand_rec());
    end

    // Drain
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, 0, none, none, none);
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d instructions never delivered, expected 0", scoreboard.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
